// File: rtl/apb_bridge_pkg.sv
// Shared types for the AXI-to-APB bridge: FSM state encoding and the command/response
// words carried through the CDC FIFOs. These types are also used by the AXI-side packer.
package apb_bridge_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    function automatic int cmd_width(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    localparam int CMD_W = cmd_width(APB_ADDR_W, APB_DATA_W);
    localparam int RSP_W = APB_DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic                  slverr;
        logic [APB_DATA_W-1:0] rdata;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_fsm_if.sv
// Bundle of the command FIFO read side, response FIFO write side and APB bus seen by
// apb_master_fsm. The master modport is the FSM; the slave modport is its environment.
interface apb_master_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W + STRB_W;

    logic              cmd_empty;
    logic [CMD_W-1:0]  cmd_rd_data;
    logic              cmd_rd_en;
    logic              rsp_full;
    logic              rsp_wr_en;
    logic [DATA_W:0]   rsp_wr_data;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              busy;

    modport master (
        input  cmd_empty, cmd_rd_data, rsp_full, prdata, pready, pslverr,
        output cmd_rd_en, rsp_wr_en, rsp_wr_data,
        output paddr, psel, penable, pwrite, pwdata, pstrb, busy
    );

    modport slave (
        output cmd_empty, cmd_rd_data, rsp_full, prdata, pready, pslverr,
        input  cmd_rd_en, rsp_wr_en, rsp_wr_data,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, busy
    );

endinterface

// File: rtl/apb_master_fsm.sv
// APB4 master: pops one command from the FWFT command FIFO, runs one APB transfer and
// pushes {pslverr, rdata} to the response FIFO. Optional ACCESS watchdog: APB_TIMEOUT_EN.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for a command; pops it and latches the APB fields
//   ST_SETUP  | APB setup phase (psel=1, penable=0)
//   ST_ACCESS | APB access phase, waits for pready (or watchdog abort)
//   ST_RESP   | holding the response until the response FIFO accepts it
module apb_master_fsm
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    apb_master_fsm_if.master  bus
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int CMD_BITS = cmd_width(ADDR_W, DATA_W);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
        $error("apb_master_fsm: DATA_W must be 8, 16 or 32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_master_fsm: TIMEOUT_CYCLES must be at least 2");
    end

    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    assign cmd_write = bus.cmd_rd_data[CMD_BITS-1];
    assign cmd_addr  = bus.cmd_rd_data[STRB_W+DATA_W +: ADDR_W];
    assign cmd_wdata = bus.cmd_rd_data[STRB_W +: DATA_W];
    assign cmd_strb  = bus.cmd_rd_data[0 +: STRB_W];

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [DATA_W:0]   rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
    logic              cmd_pop, rsp_push;
    logic [DATA_W-1:0] rdata_sel;

`ifdef APB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // Write responses never carry bus read data.
    assign rdata_sel = pwrite_q ? '0 : bus.prdata;

    always_comb begin
        state_d    = state_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        rsp_data_d = rsp_data_q;
        cmd_pop    = 1'b0;
        rsp_push   = 1'b0;
`ifdef APB_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bus.cmd_empty) begin
                    cmd_pop   = 1'b1;
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                wd_cnt_d  = '0;
`endif
            end
            ST_ACCESS: begin
                if (bus.pready) begin
                    rsp_data_d = {bus.pslverr, rdata_sel};
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = ST_RESP;
                end
`ifdef APB_TIMEOUT_EN
                // A real pready in the limit cycle wins over the abort.
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d = {1'b1, {DATA_W{1'b0}}};
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (!bus.rsp_full) begin
                    rsp_push = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wd_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
`ifdef APB_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
`endif
        end
    end

    // FIFO strobes are combinational so a pop/push lands on the same edge as the state change.
    assign bus.cmd_rd_en   = rst_n & cmd_pop;
    assign bus.rsp_wr_en   = rst_n & rsp_push;
    assign bus.rsp_wr_data = rsp_data_q;
    assign bus.paddr       = paddr_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed self-checking bench for apb_master_fsm; the watchdog section follows APB_TIMEOUT_EN.
module tb_apb_master_fsm;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    apb_master_fsm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          pi, ri, max_out, n_push;
    int          pop_cyc [3];
    int          rsp_cyc [3];
    logic [68:0] sq [3];
    logic [32:0] er [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [68:0] mk_cmd(input logic w, input logic [31:0] a,
                                           input logic [31:0] d, input logic [3:0] s);
        return {w, a, d, s};
    endfunction

    initial begin
        rst_n           = 1'b0;
        bus.cmd_empty   = 1'b0;
        bus.cmd_rd_data = mk_cmd(1'b1, 32'h99, 32'h1234, 4'hF);
        bus.rsp_full    = 1'b0;
        bus.pready      = 1'b0;
        bus.pslverr     = 1'b0;
        bus.prdata      = '0;

        // Reset state, with a non-empty FIFO that must not be popped
        nxt(); nxt(); #1;
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_rsp_data", bus.rsp_wr_data, 0);
        chk("rst_cmd_rd_en", bus.cmd_rd_en, 0);
        chk("rst_rsp_wr_en", bus.rsp_wr_en, 0);
        bus.cmd_empty = 1'b1;
        nxt(); rst_n = 1'b1;
        nxt(); #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_no_pop", bus.cmd_rd_en, 0);

        // Write, no wait states
        nxt();
        bus.cmd_empty   = 1'b0;
        bus.cmd_rd_data = mk_cmd(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
        bus.pready      = 1'b1;
        #1;
        chk("wr_pop", bus.cmd_rd_en, 1);
        chk("wr_c0_psel", bus.psel, 0);
        nxt(); bus.cmd_empty = 1'b1; #1;
        chk("wr_c1_psel", bus.psel, 1);
        chk("wr_c1_penable", bus.penable, 0);
        chk("wr_pwrite", bus.pwrite, 1);
        chk("wr_paddr", bus.paddr, 32'h10);
        chk("wr_pwdata", bus.pwdata, 32'hCAFEF00D);
        chk("wr_pstrb", bus.pstrb, 4'hF);
        chk("wr_c1_no_pop", bus.cmd_rd_en, 0);
        chk("wr_c1_busy", bus.busy, 1);
        nxt(); #1;
        chk("wr_c2_psel", bus.psel, 1);
        chk("wr_c2_penable", bus.penable, 1);
        nxt(); #1;
        chk("wr_c3_psel", bus.psel, 0);
        chk("wr_c3_penable", bus.penable, 0);
        chk("wr_c3_push", bus.rsp_wr_en, 1);
        chk("wr_c3_rsp", bus.rsp_wr_data, 33'h0);
        nxt(); #1;
        chk("wr_c4_push", bus.rsp_wr_en, 0);
        chk("wr_c4_busy", bus.busy, 0);

        // Read with 3 wait states; wdata/strb in the command must be zeroed on the bus
        nxt();
        bus.pready      = 1'b0;
        bus.cmd_empty   = 1'b0;
        bus.cmd_rd_data = mk_cmd(1'b0, 32'h20, 32'hDEADBEEF, 4'hA);
        #1;
        chk("rd_pop", bus.cmd_rd_en, 1);
        nxt(); bus.cmd_empty = 1'b1; #1;
        chk("rd_pwrite", bus.pwrite, 0);
        chk("rd_pwdata", bus.pwdata, 0);
        chk("rd_pstrb", bus.pstrb, 0);
        chk("rd_paddr_setup", bus.paddr, 32'h20);
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            chk("rd_wait_penable", bus.penable, 1);
            chk("rd_wait_paddr", bus.paddr, 32'h20);
            chk("rd_wait_no_push", bus.rsp_wr_en, 0);
        end
        nxt(); bus.pready = 1'b1; bus.prdata = 32'h12345678; #1;
        chk("rd_last_penable", bus.penable, 1);
        chk("rd_last_paddr", bus.paddr, 32'h20);
        nxt(); bus.pready = 1'b0; bus.prdata = '0; #1;
        chk("rd_push", bus.rsp_wr_en, 1);
        chk("rd_rsp", bus.rsp_wr_data, 33'h0_1234_5678);
        chk("rd_resp_psel", bus.psel, 0);
        nxt(); #1;
        chk("rd_done_busy", bus.busy, 0);

        // Slave error plus 5 cycles of response back-pressure
        nxt();
        bus.cmd_empty   = 1'b0;
        bus.cmd_rd_data = mk_cmd(1'b1, 32'h30, 32'h11112222, 4'h3);
        bus.rsp_full    = 1'b1;
        #1;
        chk("err_pop", bus.cmd_rd_en, 1);
        nxt(); bus.cmd_rd_data = mk_cmd(1'b0, 32'h40, 32'h0, 4'h0); #1;
        chk("err_setup_no_pop", bus.cmd_rd_en, 0);
        chk("err_pstrb", bus.pstrb, 4'h3);
        nxt(); bus.pslverr = 1'b1; bus.pready = 1'b0;
        nxt(); bus.pready = 1'b1;
        nxt(); bus.pready = 1'b0; bus.pslverr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_no_push", bus.rsp_wr_en, 0);
            chk("bp_rsp_stable", bus.rsp_wr_data, 33'h1_0000_0000);
            chk("bp_no_pop", bus.cmd_rd_en, 0);
            chk("bp_psel", bus.psel, 0);
            chk("bp_busy", bus.busy, 1);
            nxt();
        end
        bus.rsp_full  = 1'b0;
        bus.cmd_empty = 1'b1;
        #1;
        chk("bp_push", bus.rsp_wr_en, 1);
        chk("bp_push_rsp", bus.rsp_wr_data, 33'h1_0000_0000);
        nxt(); #1;
        chk("bp_done_busy", bus.busy, 0);
        chk("bp_done_no_push", bus.rsp_wr_en, 0);

        // Stream of three commands from a small FIFO model, pready tied high
        sq[0] = mk_cmd(1'b0, 32'h100, 32'h0, 4'h0);
        sq[1] = mk_cmd(1'b1, 32'h104, 32'h5555AAAA, 4'hF);
        sq[2] = mk_cmd(1'b0, 32'h108, 32'h0, 4'h0);
        er[0] = 33'h0_A000_0100;
        er[1] = 33'h0_0000_0000;
        er[2] = 33'h0_A000_0108;
        pi = 0; ri = 0; max_out = 0;
        nxt();
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.cmd_empty   = (pi >= 3);
            bus.cmd_rd_data = (pi < 3) ? sq[pi] : '0;
            bus.pready      = 1'b1;
            bus.prdata      = 32'hA000_0000 | bus.paddr;
            #1;
            if (bus.cmd_rd_en) begin
                if (pi < 3) pop_cyc[pi] = cyc;
                pi++;
            end
            if (bus.rsp_wr_en) begin
                if (ri < 3) begin
                    chk("stream_rsp", bus.rsp_wr_data, er[ri]);
                    rsp_cyc[ri] = cyc;
                end
                ri++;
            end
            if (pi - ri > max_out) max_out = pi - ri;
            nxt();
        end
        chk("stream_pops", pi, 3);
        chk("stream_rsps", ri, 3);
        chk("stream_first_pop", pop_cyc[0], 0);
        chk("stream_first_rsp", rsp_cyc[0], 3);
        chk("stream_gap01", pop_cyc[1] - pop_cyc[0], 4);
        chk("stream_gap12", pop_cyc[2] - pop_cyc[1], 4);
        chk("stream_outstanding", max_out, 1);

        // Reset in the middle of ACCESS drops the transfer
        bus.pready      = 1'b0;
        bus.cmd_empty   = 1'b0;
        bus.cmd_rd_data = mk_cmd(1'b0, 32'h50, 32'h0, 4'h0);
        #1;
        chk("mid_pop", bus.cmd_rd_en, 1);
        nxt(); bus.cmd_empty = 1'b1;
        nxt(); #1;
        chk("mid_access", bus.penable, 1);
        nxt(); rst_n = 1'b0; bus.cmd_empty = 1'b0; #1;
        chk("mid_rst_no_pop", bus.cmd_rd_en, 0);
        chk("mid_rst_no_push", bus.rsp_wr_en, 0);
        nxt(); rst_n = 1'b1; bus.cmd_empty = 1'b1; bus.pready = 1'b1; #1;
        chk("mid_psel", bus.psel, 0);
        chk("mid_penable", bus.penable, 0);
        chk("mid_busy", bus.busy, 0);
        n_push = 0;
        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            if (bus.rsp_wr_en) n_push++;
            chk("mid_idle_psel", bus.psel, 0);
        end
        chk("mid_no_response", n_push, 0);

        // pready held low: watchdog abort if built in, otherwise unbounded wait
        nxt();
        bus.pready      = 1'b0;
        bus.cmd_empty   = 1'b0;
        bus.cmd_rd_data = mk_cmd(1'b0, 32'h60, 32'h0, 4'h0);
        #1;
        chk("to_pop", bus.cmd_rd_en, 1);
        nxt(); bus.cmd_empty = 1'b1;
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            nxt(); #1;
            chk("to_access", bus.penable, 1);
        end
        nxt(); #1;
        chk("to_psel", bus.psel, 0);
        chk("to_penable", bus.penable, 0);
        chk("to_push", bus.rsp_wr_en, 1);
        chk("to_rsp", bus.rsp_wr_data, 33'h1_0000_0000);
        nxt(); #1;
        chk("to_idle", bus.busy, 0);
`else
        for (int i = 0; i < 12; i++) begin
            nxt(); #1;
            chk("wait_access", bus.penable, 1);
            chk("wait_no_push", bus.rsp_wr_en, 0);
        end
        nxt(); bus.pready = 1'b1; bus.prdata = 32'h55;
        nxt(); bus.pready = 1'b0; #1;
        chk("wait_push", bus.rsp_wr_en, 1);
        chk("wait_rsp", bus.rsp_wr_data, 33'h0_0000_0055);
        nxt(); #1;
        chk("wait_idle", bus.busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
